// File: rtl/basilisk_result_arbiter_pkg.sv
// basilisk_result_arbiter_pkg: result source enum, writeback payload type and request helpers
package basilisk_result_arbiter_pkg;
  localparam int BASILISK_RESULT_SOURCES = 4;
  typedef enum logic [1:0] {MULT = 2'd0, ADD = 2'd1, SQRT = 2'd2, DIVIDE = 2'd3} basilisk_result_source_t;
  typedef struct packed {
    logic [4:0]  dest_reg_addr;
    logic [31:0] result;
  } basilisk_result_t;
  function automatic logic multi_req(input logic [BASILISK_RESULT_SOURCES-1:0] req);
    return (req & (req - 1'b1)) != '0;
  endfunction
endpackage

// File: rtl/std_stream_intf.sv
// std_stream_intf: valid/ready stream of basilisk_result_t; master drives valid/data, slave drives ready
interface std_stream_intf;
  import basilisk_result_arbiter_pkg::*;
  logic valid;
  logic ready;
  basilisk_result_t data;
  modport master(output valid, data, input ready);
  modport slave(input valid, data, output ready);
endinterface

// File: rtl/basilisk_round_robin.sv
// basilisk_round_robin: combinational pick of the first request at or above ptr (mod 4); req/ptr in, one-hot grant/idx out
module basilisk_round_robin
  import basilisk_result_arbiter_pkg::*;
(
  input  logic [BASILISK_RESULT_SOURCES-1:0] req,
  input  logic [1:0]                         ptr,
  output logic [BASILISK_RESULT_SOURCES-1:0] grant,
  output logic [1:0]                         idx
);
  always_comb begin
    grant = '0;
    idx = ptr;
    for (int i = BASILISK_RESULT_SOURCES - 1; i >= 0; i--) if (req[ptr + 2'(i)]) idx = ptr + 2'(i);
    grant[idx] = |req;
  end
endmodule

// File: rtl/basilisk_result_arbiter.sv
// basilisk_result_arbiter: round-robin merge of mult/add/sqrt/divide result streams into one writeback stream; clk, async rst, four slave inputs, master writeback, writeback_source, collision
module basilisk_result_arbiter
  import basilisk_result_arbiter_pkg::*;
#(
  parameter int OUTPUT_REGISTER_MODE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  std_stream_intf.slave           mult_result_command,
  std_stream_intf.slave           add_result_command,
  std_stream_intf.slave           sqrt_result_command,
  std_stream_intf.slave           divide_result_command,
  std_stream_intf.master          writeback_command,
  output basilisk_result_source_t writeback_source,
  output logic                    collision
);
  logic [BASILISK_RESULT_SOURCES-1:0] req, grant, sel_grant, ready;
  logic [1:0] ptr, rr_idx, sel_idx;
  logic load, fire;
  basilisk_result_t pay [BASILISK_RESULT_SOURCES];
  assign req = {divide_result_command.valid, sqrt_result_command.valid, add_result_command.valid, mult_result_command.valid};
  assign pay[0] = mult_result_command.data;
  assign pay[1] = add_result_command.data;
  assign pay[2] = sqrt_result_command.data;
  assign pay[3] = divide_result_command.data;
  basilisk_round_robin u_rr (.req(req), .ptr(ptr), .grant(grant), .idx(rr_idx));
  assign fire = |req & load & ~rst;
  assign ready = sel_grant & {BASILISK_RESULT_SOURCES{load & ~rst}};
  assign mult_result_command.ready = ready[0];
  assign add_result_command.ready = ready[1];
  assign sqrt_result_command.ready = ready[2];
  assign divide_result_command.ready = ready[3];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= '0;
      collision <= 1'b0;
    end else begin
      collision <= fire & multi_req(req);
      if (fire) ptr <= sel_idx + 2'd1;
    end
  if (OUTPUT_REGISTER_MODE != 0) begin : g_reg
    logic valid_q;
    basilisk_result_t data_q;
    basilisk_result_source_t src_q;
    assign sel_idx = rr_idx;
    assign sel_grant = grant;
    assign load = ~valid_q | writeback_command.ready;
    assign writeback_command.valid = valid_q;
    assign writeback_command.data = data_q;
    assign writeback_source = src_q;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        valid_q <= 1'b0;
        data_q <= '0;
        src_q <= MULT;
      end else if (load) begin
        valid_q <= |req;
        if (|req) begin
          data_q <= pay[rr_idx];
          src_q <= basilisk_result_source_t'(rr_idx);
        end
      end
  end else begin : g_comb
    // Once a stalled payload is presented, the grant is frozen so a later higher-priority arrival cannot swap it.
    logic lock;
    logic [1:0] lock_idx;
    assign sel_idx = lock ? lock_idx : rr_idx;
    assign sel_grant = lock ? 4'(1) << lock_idx : grant;
    assign load = writeback_command.ready;
    assign writeback_command.valid = |req & ~rst;
    assign writeback_command.data = pay[sel_idx];
    assign writeback_source = rst ? MULT : basilisk_result_source_t'(sel_idx);
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        lock <= 1'b0;
        lock_idx <= '0;
      end else begin
        lock <= writeback_command.valid & ~load;
        lock_idx <= sel_idx;
      end
  end
endmodule

// File: tb/tb_basilisk_result_arbiter.sv
// tb_basilisk_result_arbiter: directed checks of registered and pass-through arbiter variants
module tb_basilisk_result_arbiter;
  import basilisk_result_arbiter_pkg::*;
  localparam logic [31:0] F15 = 32'h3FC0_0000;
  localparam logic [31:0] F8 = 32'h4100_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int checks = 0;
  int fails = 0;
  logic [3:0] v1 = '0, v0 = '0;
  basilisk_result_t p1 [4];
  basilisk_result_t p0 [4];
  logic [3:0] rdy1, rdy0;
  basilisk_result_source_t src1, src0;
  logic col1, col0;
  std_stream_intf m1(), a1(), s1(), d1(), w1();
  std_stream_intf m0(), a0(), s0(), d0(), w0();
  assign m1.valid = v1[0]; assign a1.valid = v1[1]; assign s1.valid = v1[2]; assign d1.valid = v1[3];
  assign m1.data = p1[0]; assign a1.data = p1[1]; assign s1.data = p1[2]; assign d1.data = p1[3];
  assign m0.valid = v0[0]; assign a0.valid = v0[1]; assign s0.valid = v0[2]; assign d0.valid = v0[3];
  assign m0.data = p0[0]; assign a0.data = p0[1]; assign s0.data = p0[2]; assign d0.data = p0[3];
  assign rdy1 = {d1.ready, s1.ready, a1.ready, m1.ready};
  assign rdy0 = {d0.ready, s0.ready, a0.ready, m0.ready};
  basilisk_result_arbiter #(.OUTPUT_REGISTER_MODE(1)) u1 (
    .clk(clk), .rst(rst), .mult_result_command(m1), .add_result_command(a1), .sqrt_result_command(s1),
    .divide_result_command(d1), .writeback_command(w1), .writeback_source(src1), .collision(col1));
  basilisk_result_arbiter #(.OUTPUT_REGISTER_MODE(0)) u0 (
    .clk(clk), .rst(rst), .mult_result_command(m0), .add_result_command(a0), .sqrt_result_command(s0),
    .divide_result_command(d0), .writeback_command(w0), .writeback_source(src0), .collision(col0));

  function automatic basilisk_result_t mk(input logic [4:0] d, input logic [31:0] r);
    mk.dest_reg_addr = d;
    mk.result = r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 4; i++) begin p1[i] = mk(5'(i), 32'h0); p0[i] = mk(5'(i), 32'h0); end
    w1.ready = 1'b1; w0.ready = 1'b1;
    v1 = 4'b1111; v0 = 4'b1111;
    #2;
    checks++; if (rdy1 !== 4'b0000) begin fails++; $display("FAIL reset_ready1: got %b want 0000", rdy1); end
    checks++; if (rdy0 !== 4'b0000) begin fails++; $display("FAIL reset_ready0: got %b want 0000", rdy0); end
    checks++; if (w1.valid !== 1'b0) begin fails++; $display("FAIL reset_valid1: got %b want 0", w1.valid); end
    checks++; if (w0.valid !== 1'b0) begin fails++; $display("FAIL reset_valid0: got %b want 0", w0.valid); end
    checks++; if (src1 !== MULT || src0 !== MULT) begin fails++; $display("FAIL reset_source: got %0d/%0d want 0/0", src1, src0); end
    checks++; if (col1 !== 1'b0 || col0 !== 1'b0) begin fails++; $display("FAIL reset_collision: got %b/%b want 0/0", col1, col0); end
    v1 = '0; v0 = '0;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_single;
    v1[3] = 1'b1; p1[3] = mk(5'd6, F15);
    v0[3] = 1'b1; p0[3] = mk(5'd6, F15);
    #1;
    checks++; if (rdy1 !== 4'b1000) begin fails++; $display("FAIL single_ready1: got %b want 1000", rdy1); end
    checks++; if (w1.valid !== 1'b0) begin fails++; $display("FAIL single_latency1: got %b want 0", w1.valid); end
    checks++; if (w0.valid !== 1'b1 || w0.data !== mk(5'd6, F15) || src0 !== DIVIDE) begin fails++; $display("FAIL single_mode0: got v%b %h src %0d want v1 %h src 3", w0.valid, w0.data, src0, mk(5'd6, F15)); end
    checks++; if (rdy0 !== 4'b1000) begin fails++; $display("FAIL single_ready0: got %b want 1000", rdy0); end
    tick;
    v1 = '0; v0 = '0;
    #1;
    checks++; if (w1.valid !== 1'b1 || w1.data !== mk(5'd6, F15) || src1 !== DIVIDE) begin fails++; $display("FAIL single_mode1: got v%b %h src %0d want v1 %h src 3", w1.valid, w1.data, src1, mk(5'd6, F15)); end
    checks++; if (col1 !== 1'b0) begin fails++; $display("FAIL single_collision: got %b want 0", col1); end
    tick;
    checks++; if (w1.valid !== 1'b0) begin fails++; $display("FAIL single_clear: got %b want 0", w1.valid); end
  endtask

  task automatic test_all_four;
    for (int i = 0; i < 4; i++) p1[i] = mk(5'(i + 1), 32'h100 + 32'(i));
    v1 = 4'b1111;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (rdy1 !== 4'(1) << k) begin fails++; $display("FAIL all4_ready%0d: got %b want %b", k, rdy1, 4'(1) << k); end
      tick;
      v1[k] = 1'b0;
      #1;
      checks++; if (w1.valid !== 1'b1 || w1.data !== mk(5'(k + 1), 32'h100 + 32'(k)) || src1 !== basilisk_result_source_t'(k)) begin fails++; $display("FAIL all4_out%0d: got v%b %h src %0d want v1 %h src %0d", k, w1.valid, w1.data, src1, mk(5'(k + 1), 32'h100 + 32'(k)), k); end
      checks++; if (col1 !== (k < 3)) begin fails++; $display("FAIL all4_collision%0d: got %b want %b", k, col1, k < 3); end
    end
    tick;
    checks++; if (w1.valid !== 1'b0 || col1 !== 1'b0) begin fails++; $display("FAIL all4_drain: got v%b c%b want 0/0", w1.valid, col1); end
  endtask

  task automatic test_fairness;
    p1[0] = mk(5'd10, 32'hA); p1[2] = mk(5'd11, 32'hB);
    v1 = 4'b0101;
    #1;
    for (int k = 0; k < 8; k++) begin
      checks++; if (rdy1 !== ((k % 2 == 0) ? 4'b0001 : 4'b0100)) begin fails++; $display("FAIL fair_ready%0d: got %b want %b", k, rdy1, (k % 2 == 0) ? 4'b0001 : 4'b0100); end
      tick;
      checks++; if (src1 !== ((k % 2 == 0) ? MULT : SQRT) || col1 !== 1'b1) begin fails++; $display("FAIL fair_grant%0d: got src %0d c%b want src %0d c1", k, src1, col1, (k % 2 == 0) ? 0 : 2); end
    end
    v1 = '0;
    tick;
    checks++; if (w1.valid !== 1'b0) begin fails++; $display("FAIL fair_drain: got %b want 0", w1.valid); end
  endtask

  task automatic test_back_pressure;
    w1.ready = 1'b0;
    v1[1] = 1'b1; p1[1] = mk(5'd8, F8);
    #1;
    checks++; if (rdy1 !== 4'b0010) begin fails++; $display("FAIL bp_add_ready: got %b want 0010", rdy1); end
    tick;
    v1[1] = 1'b0;
    v1[0] = 1'b1; p1[0] = mk(5'd9, 32'h3F80_0000);
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (w1.valid !== 1'b1 || w1.data !== mk(5'd8, F8) || src1 !== ADD || rdy1 !== 4'b0000) begin fails++; $display("FAIL bp_hold%0d: got v%b %h src %0d rdy %b want v1 %h src 1 rdy 0000", k, w1.valid, w1.data, src1, rdy1, mk(5'd8, F8)); end
      tick;
    end
    w1.ready = 1'b1;
    #1;
    checks++; if (rdy1 !== 4'b0001) begin fails++; $display("FAIL bp_release_ready: got %b want 0001", rdy1); end
    tick;
    v1[0] = 1'b0;
    #1;
    checks++; if (w1.valid !== 1'b1 || w1.data !== mk(5'd9, 32'h3F80_0000) || src1 !== MULT) begin fails++; $display("FAIL bp_follow: got v%b %h src %0d want v1 %h src 0", w1.valid, w1.data, src1, mk(5'd9, 32'h3F80_0000)); end
    tick;
  endtask

  task automatic test_reset_mid_stall;
    w1.ready = 1'b0;
    v1[1] = 1'b1; p1[1] = mk(5'd12, 32'hDEAD);
    #1;
    tick;
    v1[1] = 1'b0;
    #1;
    checks++; if (w1.valid !== 1'b1) begin fails++; $display("FAIL rst_stall_loaded: got %b want 1", w1.valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (w1.valid !== 1'b0 || src1 !== MULT) begin fails++; $display("FAIL rst_async_clear: got v%b src %0d want v0 src 0", w1.valid, src1); end
    #2 rst = 1'b0;
    w1.ready = 1'b1;
    v1 = 4'b1111;
    #1;
    checks++; if (rdy1 !== 4'b0001) begin fails++; $display("FAIL rst_pointer: got %b want 0001", rdy1); end
    v1 = '0;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++; if (w1.valid !== 1'b0) begin fails++; $display("FAIL rst_no_replay%0d: got %b want 0", k, w1.valid); end
    end
  endtask

  task automatic test_mode0_lock;
    w0.ready = 1'b0;
    v0[2] = 1'b1; p0[2] = mk(5'd5, 32'h4000_0000);
    #1;
    checks++; if (w0.valid !== 1'b1 || w0.data !== mk(5'd5, 32'h4000_0000) || src0 !== SQRT || rdy0 !== 4'b0000) begin fails++; $display("FAIL lock_present: got v%b %h src %0d rdy %b want v1 %h src 2 rdy 0000", w0.valid, w0.data, src0, rdy0, mk(5'd5, 32'h4000_0000)); end
    tick;
    v0[0] = 1'b1; p0[0] = mk(5'd7, 32'h4040_0000);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (w0.data !== mk(5'd5, 32'h4000_0000) || src0 !== SQRT) begin fails++; $display("FAIL lock_hold%0d: got %h src %0d want %h src 2", k, w0.data, src0, mk(5'd5, 32'h4000_0000)); end
      tick;
    end
    w0.ready = 1'b1;
    #1;
    checks++; if (rdy0 !== 4'b0100) begin fails++; $display("FAIL lock_transfer_ready: got %b want 0100", rdy0); end
    tick;
    v0[2] = 1'b0;
    #1;
    checks++; if (w0.data !== mk(5'd7, 32'h4040_0000) || src0 !== MULT || rdy0 !== 4'b0001) begin fails++; $display("FAIL lock_next_mult: got %h src %0d rdy %b want %h src 0 rdy 0001", w0.data, src0, rdy0, mk(5'd7, 32'h4040_0000)); end
    checks++; if (col0 !== 1'b1) begin fails++; $display("FAIL lock_collision: got %b want 1", col0); end
    tick;
    v0[0] = 1'b0;
    #1;
    checks++; if (w0.valid !== 1'b0) begin fails++; $display("FAIL lock_drain: got %b want 0", w0.valid); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_all_four;
    test_fairness;
    test_back_pressure;
    test_reset_mid_stall;
    test_mode0_lock;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
